// File: rtl/vip_pattern_gen_if.sv
// Video stream bundle produced by vip_pattern_gen and consumed by the vip stages.
//   post_vs    : vertical sync, active high, whole lines
//   post_de    : active-pixel strobe
//   post_data  : {R[23:16], G[15:8], B[7:0]}, zero whenever post_de is low
//   frame_done : one-clock pulse after the last clock of each frame
interface vip_pattern_gen_if;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;
    logic        frame_done;

    modport master (output post_vs, post_de, post_data, frame_done);
    modport slave  (input  post_vs, post_de, post_data, frame_done);
endinterface

// File: rtl/vip_pattern_gen.sv
// Test-pattern video source: programmable raster and blanking, with colour
// bars, gray ramp, solid colour or a fixed colour cast as the payload.
//   clk       : pixel clock
//   rst_n     : synchronous active-low reset
//   en        : run request, sampled in IDLE and at the end of each frame
//   pat_sel   : 0 bars, 1 gray ramp, 2 solid, 3 cast gray
//   solid_rgb : colour for pattern 2
//   vid       : video output bundle (master side)
//
// state | meaning
// IDLE  | counters parked at 0,0, all outputs low
// RUN   | raster counters advance every clock, outputs follow one clock later
module vip_pattern_gen #(
    parameter int COL    = 1280,
    parameter int ROW    = 720,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int H_FP   = 110,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    parameter int V_FP   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        pat_sel,
    input  logic [23:0]       solid_rgb,
    vip_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BP + COL + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + ROW + V_FP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int H_ACT1  = H_ACT0 + COL;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int V_ACT1  = V_ACT0 + ROW;
    localparam int BAR_W   = COL / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic [1:0]     pat_q;
    logic [23:0]    solid_q;
    logic [BW-1:0]  bar_pix;
    logic [2:0]     bar_idx;

    logic           line_end;
    logic           wrap_pos;
    logic           at_origin;
    logic           active;
    logic           line_start;
    logic [BW-1:0]  cur_pix;
    logic [BW-1:0]  nxt_pix;
    logic [2:0]     cur_idx;
    logic [2:0]     nxt_idx;
    logic [7:0]     x8;
    logic [23:0]    pix_rgb;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    always_comb begin
        line_end   = (hcnt == HW'(H_TOTAL - 1));
        wrap_pos   = line_end && (vcnt == VW'(V_TOTAL - 1));
        at_origin  = (hcnt == '0) && (vcnt == '0);
        active     = (hcnt >= HW'(H_ACT0)) && (hcnt <= HW'(H_ACT1 - 1)) &&
                     (vcnt >= VW'(V_ACT0)) && (vcnt <= VW'(V_ACT1 - 1));
        line_start = (hcnt == HW'(H_ACT0));

        // Bar position restarts on the first active pixel of every line, so the
        // registered copy never needs clearing during blanking.
        cur_pix = line_start ? '0   : bar_pix;
        cur_idx = line_start ? 3'd0 : bar_idx;
        if (cur_pix == BW'(BAR_W - 1)) begin
            nxt_pix = '0;
            nxt_idx = cur_idx + 3'd1;
        end else begin
            nxt_pix = cur_pix + BW'(1);
            nxt_idx = cur_idx;
        end

        x8 = 8'(hcnt - HW'(H_ACT0));
        case (pat_q)
            2'd0:    pix_rgb = bar_rgb(cur_idx);
            2'd1:    pix_rgb = {x8, x8, x8};
            2'd2:    pix_rgb = solid_q;
            default: pix_rgb = 24'hA08060;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            hcnt           <= '0;
            vcnt           <= '0;
            pat_q          <= 2'd0;
            solid_q        <= 24'h0;
            bar_pix        <= '0;
            bar_idx        <= 3'd0;
            vid.post_vs    <= 1'b0;
            vid.post_de    <= 1'b0;
            vid.post_data  <= 24'h0;
            vid.frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hcnt           <= '0;
                    vcnt           <= '0;
                    vid.post_vs    <= 1'b0;
                    vid.post_de    <= 1'b0;
                    vid.post_data  <= 24'h0;
                    vid.frame_done <= 1'b0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    vid.post_vs    <= (vcnt < VW'(V_SYNC));
                    vid.post_de    <= active;
                    vid.post_data  <= active ? pix_rgb : 24'h0;
                    vid.frame_done <= wrap_pos;

                    // Origin is never an active pixel, so the new pattern is
                    // in place before the first pixel of the frame uses it.
                    if (at_origin) begin
                        pat_q   <= pat_sel;
                        solid_q <= solid_rgb;
                    end
                    if (active) begin
                        bar_pix <= nxt_pix;
                        bar_idx <= nxt_idx;
                    end

                    if (line_end) begin
                        hcnt <= '0;
                        if (wrap_pos) begin
                            vcnt <= '0;
                            if (!en) begin
                                state <= IDLE;
                            end
                        end else begin
                            vcnt <= vcnt + VW'(1);
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vip_pattern_gen.sv
module tb_vip_pattern_gen;
    localparam int COL    = 16;
    localparam int COL_G  = 512;
    localparam int ROW    = 4;
    localparam int H_SYNC = 2;
    localparam int H_BP   = 2;
    localparam int H_FP   = 2;
    localparam int V_SYNC = 1;
    localparam int V_BP   = 1;
    localparam int V_FP   = 1;
    localparam int V_TOTAL = V_SYNC + V_BP + ROW + V_FP;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic        vs;
        logic        de;
        logic        fd;
        logic [23:0] data;
    } out_t;

    typedef struct {
        bit          run;
        int          pos;
        logic [1:0]  pat;
        logic [23:0] solid;
    } mst_t;

    typedef struct {
        int          cyc;
        logic        vs;
        logic        de;
        logic        fd;
        logic [23:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en_g;
    logic [1:0]  pat_sel, pat_g;
    logic [23:0] solid_rgb, solid_g;

    vip_pattern_gen_if vid();
    vip_pattern_gen_if vid_g();

    vip_pattern_gen #(.COL(COL), .ROW(ROW), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
                      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb), .vid(vid));

    vip_pattern_gen #(.COL(COL_G), .ROW(ROW), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
                      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)) dut_g (
        .clk(clk), .rst_n(rst_n), .en(en_g), .pat_sel(pat_g), .solid_rgb(solid_g), .vid(vid_g));

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    mst_t m, mg;

    // Reference: each frame is a linear run of H_TOTAL*V_TOTAL positions; the
    // outputs seen after an edge describe the position held before that edge.
    function automatic out_t model_step(inout mst_t s, input int col, input logic r_n,
                                        input logic en_i, input logic [1:0] ps,
                                        input logic [23:0] sr);
        out_t e;
        int ht, frame, line, px, x;
        e = '0;
        ht = H_SYNC + H_BP + col + H_FP;
        frame = ht * V_TOTAL;
        if (!r_n) begin
            s.run = 0; s.pos = 0; s.pat = 2'd0; s.solid = 24'h0;
        end else if (!s.run) begin
            if (en_i) begin
                s.run = 1; s.pos = 0;
            end
        end else begin
            if (s.pos == 0) begin
                s.pat = ps; s.solid = sr;
            end
            line = s.pos / ht;
            px   = s.pos % ht;
            x    = px - (H_SYNC + H_BP);
            e.vs = (line < V_SYNC);
            e.de = (x >= 0) && (x < col) && (line >= V_SYNC + V_BP) && (line < V_SYNC + V_BP + ROW);
            if (e.de) begin
                case (s.pat)
                    2'd0:    e.data = BARS[x / (col / 8)];
                    2'd1:    e.data = {x[7:0], x[7:0], x[7:0]};
                    2'd2:    e.data = s.solid;
                    default: e.data = 24'hA08060;
                endcase
            end
            e.fd = (s.pos == frame - 1);
            if (e.fd) begin
                s.pos = 0;
                if (!en_i) s.run = 0;
            end else begin
                s.pos++;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [26:0] cur_out();
        return {vid.post_vs, vid.post_de, vid.frame_done, vid.post_data};
    endfunction

    task automatic chk_o(input string name, input logic vs, input logic de, input logic fd,
                         input logic [23:0] d);
        chk(name, cur_out(), {vs, de, fd, d});
    endtask

    task automatic tick();
        out_t e, eg;
        @(posedge clk);
        e  = model_step(m,  COL,   rst_n, en,   pat_sel, solid_rgb);
        eg = model_step(mg, COL_G, rst_n, en_g, pat_g,   solid_g);
        #1;
        cyc++;
        chk("model",   cur_out(), e);
        chk("model_g", {vid_g.post_vs, vid_g.post_de, vid_g.frame_done, vid_g.post_data}, eg);
    endtask

    task automatic start();
        en = 1'b1;
        tick();
        cyc = 0;
    endtask

    task automatic drain();
        en = 1'b0;
        for (int i = 0; i < 160; i++) tick();
        pat_sel = 2'd0;
    endtask

    vec_t tbl[$];
    int   ti;
    int   de_cnt, vs_cnt, vs_rise, overlap, gx;
    logic prev_vs, any_nz;

    initial begin
        tbl.push_back('{0,   1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{1,   1'b1, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{22,  1'b1, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{23,  1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{48,  1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{49,  1'b0, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{50,  1'b0, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{51,  1'b0, 1'b1, 1'b0, 24'hFFFF00});
        tbl.push_back('{53,  1'b0, 1'b1, 1'b0, 24'h00FFFF});
        tbl.push_back('{55,  1'b0, 1'b1, 1'b0, 24'h00FF00});
        tbl.push_back('{57,  1'b0, 1'b1, 1'b0, 24'hFF00FF});
        tbl.push_back('{59,  1'b0, 1'b1, 1'b0, 24'hFF0000});
        tbl.push_back('{61,  1'b0, 1'b1, 1'b0, 24'h0000FF});
        tbl.push_back('{63,  1'b0, 1'b1, 1'b0, 24'h000000});
        tbl.push_back('{64,  1'b0, 1'b1, 1'b0, 24'h000000});
        tbl.push_back('{65,  1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{71,  1'b0, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{86,  1'b0, 1'b1, 1'b0, 24'h000000});
        tbl.push_back('{87,  1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{115, 1'b0, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{130, 1'b0, 1'b1, 1'b0, 24'h000000});
        tbl.push_back('{131, 1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{153, 1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{154, 1'b0, 1'b0, 1'b1, 24'h000000});
        tbl.push_back('{155, 1'b1, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{176, 1'b1, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{177, 1'b0, 1'b0, 1'b0, 24'h000000});
        tbl.push_back('{203, 1'b0, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{205, 1'b0, 1'b1, 1'b0, 24'hFFFF00});
        tbl.push_back('{308, 1'b0, 1'b0, 1'b1, 24'h000000});
        tbl.push_back('{309, 1'b1, 1'b0, 1'b0, 24'h000000});

        m = '{0, 0, 2'd0, 24'h0};
        mg = '{0, 0, 2'd0, 24'h0};
        rst_n = 1'b0; en = 1'b0; en_g = 1'b0;
        pat_sel = 2'd0; pat_g = 2'd1; solid_rgb = 24'h0; solid_g = 24'h0;

        // Reset and idle
        for (int i = 0; i < 3; i++) tick();
        chk_o("reset_state", 1'b0, 1'b0, 1'b0, 24'h0);
        rst_n = 1'b1;
        any_nz = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cur_out() != '0) any_nz = 1'b1;
        end
        chk("idle_zero", {26'b0, any_nz}, 27'b0);

        // Raster and colour bars
        ti = 0;
        de_cnt = 0; vs_cnt = 0; vs_rise = 0; overlap = 0;
        start();
        prev_vs = vid.post_vs;
        for (int c = 0; c <= 320; c++) begin
            if (c > 0) tick();
            while (ti < tbl.size() && tbl[ti].cyc == cyc) begin
                chk_o($sformatf("raster_c%0d", cyc), tbl[ti].vs, tbl[ti].de, tbl[ti].fd, tbl[ti].data);
                ti++;
            end
            if (cyc >= 1 && cyc <= 154) begin
                de_cnt  += int'(vid.post_de);
                vs_cnt  += int'(vid.post_vs);
                if (vid.post_vs && !prev_vs) vs_rise++;
                if (vid.post_vs && vid.post_de) overlap++;
            end
            prev_vs = vid.post_vs;
        end
        chk("raster_table_used", 27'(ti), 27'(tbl.size()));
        chk("de_per_frame", 27'(de_cnt), 27'd64);
        chk("vs_per_frame", 27'(vs_cnt), 27'd22);
        chk("vs_rises", 27'(vs_rise), 27'd1);
        chk("vs_de_overlap", 27'(overlap), 27'd0);
        drain();

        // Pattern latch: changes mid-frame land on the next frame
        start();
        for (int c = 1; c <= 360; c++) begin
            tick();
            if (cyc == 115) chk_o("latch_cur_frame", 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
            if (cyc == 203) chk_o("latch_solid_first", 1'b0, 1'b1, 1'b0, 24'h123456);
            if (cyc == 218) chk_o("latch_solid_last", 1'b0, 1'b1, 1'b0, 24'h123456);
            if (cyc == 357) chk_o("cast_gray", 1'b0, 1'b1, 1'b0, 24'hA08060);
            if (cyc == 80) begin
                pat_sel = 2'd2; solid_rgb = 24'h123456;
            end
            if (cyc == 250) pat_sel = 2'd3;
        end
        drain();

        // en dropped mid-frame: frame completes, then IDLE
        start();
        any_nz = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (cyc == 60) en = 1'b0;
            if (cyc == 153) chk_o("drop_c153", 1'b0, 1'b0, 1'b0, 24'h0);
            if (cyc == 154) chk_o("drop_frame_done", 1'b0, 1'b0, 1'b1, 24'h0);
            if (cyc > 154 && cur_out() != '0) any_nz = 1'b1;
        end
        chk("drop_idle_zero", {26'b0, any_nz}, 27'b0);

        // Reset mid-frame, then restart from 0,0
        start();
        for (int c = 1; c <= 70; c++) tick();
        rst_n = 1'b0;
        tick();
        chk_o("rst_next_clock", 1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        tick();
        rst_n = 1'b1;
        start();
        chk_o("restart_c0", 1'b0, 1'b0, 1'b0, 24'h0);
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (cyc == 1)  chk_o("restart_vs_c1", 1'b1, 1'b0, 1'b0, 24'h0);
            if (cyc == 23) chk_o("restart_vs_c23", 1'b0, 1'b0, 1'b0, 24'h0);
            if (cyc == 49) chk_o("restart_de_c49", 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
        end
        drain();

        // Gray ramp on the 512-wide instance
        pat_g = 2'd1; en_g = 1'b1;
        tick();
        en_g = 1'b0;
        gx = 0;
        for (int c = 0; c < 3700; c++) begin
            tick();
            if (vid_g.post_de && gx < COL_G) begin
                if (gx == 0 || gx == 1 || gx == 255 || gx == 256 || gx == 511)
                    chk($sformatf("gray_x%0d", gx), {3'b0, vid_g.post_data}, {3'b0, {3{8'(gx)}}});
                gx++;
            end
        end
        chk("gray_line_len", 27'(gx), 27'd512);

        // Randomised run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) en = ($urandom_range(0, 3) != 0);
            if (i % 500 == 0) en_g = ($urandom_range(0, 1) != 0);
            if (i % 23 == 0) begin
                pat_sel = 2'($urandom); solid_rgb = 24'($urandom);
                pat_g = 2'($urandom); solid_g = 24'($urandom);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
